// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared state encoding and constants for the program-counter generator
package pc_gen_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALT} state_e;
  localparam int PC_STEP = 4;
  localparam int DEF_XLEN = 32;
endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: holds a redirect target that arrived while fetch could not advance
module pc_redirect_buf #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            adv,
  input  logic            redirect,
  input  logic [XLEN-1:0] target,
  output logic            pend_valid,
  output logic [XLEN-1:0] pend_target
);
  logic            pend_valid_d, pend_valid_q;
  logic [XLEN-1:0] pend_target_d, pend_target_q;
  always_comb begin
    pend_valid_d  = adv ? 1'b0 : (en & redirect) ? 1'b1 : pend_valid_q;
    pend_target_d = (en & ~adv & redirect) ? target : pend_target_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else begin
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end
  assign pend_valid  = pend_valid_q;
  assign pend_target = pend_target_q;
endmodule

// File: rtl/pc_gen.sv
// pc_gen: PC register, fetch handshake and next-PC mux; PC_MISALIGN_TRAP_EN halts on misaligned targets
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_gen_out,
  input  logic [XLEN-1:0] target_addr,
  input  logic            stall,
  output logic            if_req,
  output logic [XLEN-1:0] if_addr,
  input  logic            if_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign
);
  state_e          state_d, state_q;
  logic [XLEN-1:0] pc_d, pc_q, tgt, pend_target;
  logic            run, adv, redir, pend_valid;
`ifdef PC_MISALIGN_TRAP_EN
  logic            bad, misalign_d, misalign_q;
`endif
  pc_redirect_buf #(.XLEN(XLEN)) u_buf (
    .clk         (clk),
    .rst         (rst),
    .en          (run),
    .adv         (adv),
    .redirect    (pc_gen_out),
    .target      (target_addr),
    .pend_valid  (pend_valid),
    .pend_target (pend_target)
  );
  assign pc_plus4 = pc_q + XLEN'(PC_STEP);
  always_comb begin
    run   = state_q == RUN;
    adv   = run & if_ready & ~stall;
    redir = pc_gen_out | pend_valid;
    tgt   = pc_gen_out ? target_addr : pend_target;
`ifdef PC_MISALIGN_TRAP_EN
    bad        = adv & redir & (tgt[1:0] != 2'b00);
    pc_d       = (adv & ~bad) ? (redir ? tgt : pc_plus4) : pc_q;
    state_d    = state_q == BOOT ? RUN : bad ? HALT : state_q;
    misalign_d = misalign_q | bad;
`else
    pc_d    = adv ? (redir ? tgt & ~XLEN'(3) : pc_plus4) : pc_q;
    state_d = state_q == BOOT ? RUN : state_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end
`ifdef PC_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else misalign_q <= misalign_d;
  end
  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif
  assign if_req  = run;
  assign if_addr = pc_q;
  assign pc      = pc_q;
endmodule
